// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer
//   Front end of the MIPS datapath: holds the PC, fetches one instruction
//   word at a time from the icache, presents it to the control unit and,
//   once the datapath retires it, selects the next PC from the decoded
//   control outputs.
//
// Ports
//   CLK, RST          clock / synchronous active-high reset
//   ihit, iload       icache completion and returned instruction word
//   iREN, iaddr       icache read request (iaddr always equals pc)
//   imemload          latched instruction for the control unit
//   instr_valid       imemload holds the instruction being executed
//   exec_done         datapath retired the current instruction
//   PCsrc, flagZero,
//   BranchAddr, addr,
//   rdat1, halt       decoded next-PC controls, sampled with exec_done
//   pc, pc_plus4      PC of the current instruction and its successor
//   halted            sequencer stopped until reset
module ifetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic [2:0]        PCsrc,
    input  logic              flagZero,
    input  logic [WORD_W-1:0] BranchAddr,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] rdat1,
    input  logic              halt,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALTED
    } state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] branch_tgt;
    logic              unused_bits;

    // Bits of the decode inputs that never influence the next PC.
    assign unused_bits = &{1'b0, addr[31:26], rdat1[1:0], next_pc[1:0]};

    always_comb begin
        pc_plus4   = pc + 32'd4;
        branch_tgt = pc_plus4 + BranchAddr;
        case (PCsrc)
            3'd2:    next_pc = {rdat1[31:2], 2'b00};
            3'd3:    next_pc = {pc_plus4[31:28], addr[25:0], 2'b00};
            3'd4:    next_pc = flagZero ? pc_plus4 : branch_tgt;
            3'd5:    next_pc = flagZero ? branch_tgt : pc_plus4;
            default: next_pc = pc_plus4;
        endcase
    end

    // Request/valid/halted are masked by RST so the reset cycle itself
    // shows an idle front end whatever state the register still holds.
    always_comb begin
        state_n     = state;
        iREN        = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        iaddr       = pc;
        case (state)
            FETCH: begin
                iREN = ~RST;
                if (ihit) state_n = EXEC;
            end
            EXEC: begin
                instr_valid = ~RST;
                if (exec_done) state_n = halt ? HALTED : FETCH;
            end
            HALTED: begin
                halted = ~RST;
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= {PC_INIT[31:2], 2'b00};
            imemload <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && ihit)
                imemload <= iload;
            if (state == EXEC && exec_done && !halt)
                pc <= {next_pc[31:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
module tb_ifetch_sequencer;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] imemload;
    logic        instr_valid;
    logic        exec_done;
    logic [2:0]  PCsrc;
    logic        flagZero;
    logic [31:0] BranchAddr;
    logic [31:0] addr;
    logic [31:0] rdat1;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;

    ifetch_sequencer #(.PC_INIT(PC_INIT), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
        .iaddr(iaddr), .imemload(imemload), .instr_valid(instr_valid),
        .exec_done(exec_done), .PCsrc(PCsrc), .flagZero(flagZero),
        .BranchAddr(BranchAddr), .addr(addr), .rdat1(rdat1), .halt(halt),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference: architectural PC and last fetched word.
    logic [31:0] mpc;
    logic [31:0] mimem;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] src,
                                             input logic z, input logic [31:0] br,
                                             input logic [31:0] a, input logic [31:0] r);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (src)
            3'd2:    return r & 32'hFFFF_FFFC;
            3'd3:    return (seq & 32'hF000_0000) | ((a & 32'h03FF_FFFF) << 2);
            3'd4:    return z ? seq : seq + br;
            3'd5:    return z ? seq + br : seq;
            default: return seq;
        endcase
    endfunction

    task automatic randomize_controls();
        PCsrc      = 3'($urandom);
        flagZero   = 1'($urandom);
        BranchAddr = $urandom;
        addr       = $urandom;
        rdat1      = $urandom;
        halt       = 1'($urandom);
    endtask

    // Fetch one word after 'waits' cycles without ihit.
    task automatic fetch_word(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            ihit = 1'b0;
            randomize_controls();
            exec_done = 1'($urandom);
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== mpc || instr_valid !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("FAIL fetch_wait: iREN=%b iaddr=%h instr_valid=%b halted=%b, want 1 %h 0 0",
                         iREN, iaddr, instr_valid, halted, mpc);
            end
            tick();
        end
        ihit  = 1'b1;
        iload = word;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== mpc) begin
            failures++;
            $display("FAIL fetch_hit: iREN=%b iaddr=%h, want 1 %h", iREN, iaddr, mpc);
        end
        tick();
        ihit  = 1'b0;
        iload = $urandom;
        mimem = word;
        checks++;
        if (instr_valid !== 1'b1 || imemload !== mimem || pc !== mpc || iREN !== 1'b0) begin
            failures++;
            $display("FAIL fetch_land: instr_valid=%b imemload=%h pc=%h iREN=%b, want 1 %h %h 0",
                     instr_valid, imemload, pc, iREN, mimem, mpc);
        end
    endtask

    // Hold in EXEC for 'delay' cycles (random junk on controls and ihit), then retire.
    task automatic exec_instr(input int delay, input logic [2:0] src, input logic z,
                              input logic [31:0] br, input logic [31:0] a,
                              input logic [31:0] r, input logic hlt);
        for (int i = 0; i < delay; i++) begin
            exec_done = 1'b0;
            ihit      = 1'($urandom);
            iload     = $urandom;
            randomize_controls();
            #1;
            checks++;
            if (instr_valid !== 1'b1 || iREN !== 1'b0 || imemload !== mimem ||
                pc !== mpc || pc_plus4 !== mpc + 32'd4 || iaddr !== mpc) begin
                failures++;
                $display("FAIL exec_hold: valid=%b iREN=%b imemload=%h pc=%h pc4=%h, want 1 0 %h %h %h",
                         instr_valid, iREN, imemload, pc, pc_plus4, mimem, mpc, mpc + 32'd4);
            end
            tick();
        end
        exec_done  = 1'b1;
        ihit       = 1'($urandom);
        PCsrc      = src;
        flagZero   = z;
        BranchAddr = br;
        addr       = a;
        rdat1      = r;
        halt       = hlt;
        tick();
        exec_done = 1'b0;
        ihit      = 1'b0;
        halt      = 1'b0;
        if (!hlt) mpc = ref_next(mpc, src, z, br, a, r);
        checks++;
        if (hlt) begin
            if (halted !== 1'b1 || pc !== mpc || iREN !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL exec_halt: halted=%b pc=%h iREN=%b valid=%b, want 1 %h 0 0",
                         halted, pc, iREN, instr_valid, mpc);
            end
        end else if (iREN !== 1'b1 || iaddr !== mpc || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL exec_next: iREN=%b iaddr=%h valid=%b, want 1 %h 0",
                     iREN, iaddr, instr_valid, mpc);
        end
    endtask

    task automatic set_pc(input logic [31:0] target);
        fetch_word(0, $urandom);
        exec_instr(0, 3'd2, 1'b0, 32'h0, 32'h0, target, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit = 1'b1; iload = $urandom; exec_done = 1'b1;
        randomize_controls();
        tick();
        tick();
        checks++;
        if (iREN !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            pc !== PC_INIT || imemload !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: iREN=%b valid=%b halted=%b pc=%h imemload=%h, want 0 0 0 %h 0",
                     iREN, instr_valid, halted, pc, imemload, PC_INIT);
        end
        RST = 1'b0; ihit = 1'b0; exec_done = 1'b0;
        mpc = PC_INIT; mimem = 32'h0;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== PC_INIT) begin
            failures++;
            $display("FAIL reset_release: iREN=%b iaddr=%h, want 1 %h", iREN, iaddr, PC_INIT);
        end
    endtask

    task automatic test_basic_fetch();
        fetch_word(2, 32'h2001_0005);
        exec_instr(1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (iaddr !== 32'h4) begin
            failures++;
            $display("FAIL basic_seq: iaddr=%h, want 00000004", iaddr);
        end
    endtask

    task automatic test_branches();
        logic [31:0] want [4] = '{32'h3C, 32'h44, 32'h54, 32'h44};
        logic [2:0]  srcs [4] = '{3'd5, 3'd5, 3'd4, 3'd4};
        logic        zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] brs  [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h40);
            fetch_word(1, $urandom);
            exec_instr(2, srcs[i], zs[i], brs[i], $urandom, $urandom, 1'b0);
            checks++;
            if (iaddr !== want[i]) begin
                failures++;
                $display("FAIL branch_%0d: iaddr=%h, want %h", i, iaddr, want[i]);
            end
        end
    endtask

    task automatic test_jumps();
        fetch_word(0, $urandom);
        exec_instr(0, 3'd2, 1'b0, 32'h0, 32'h0, 32'h0000_1237, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_1234) begin
            failures++;
            $display("FAIL jr_align: iaddr=%h, want 00001234", iaddr);
        end
        set_pc(32'h8000_0100);
        fetch_word(0, $urandom);
        exec_instr(1, 3'd3, 1'b0, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
        checks++;
        if (iaddr !== 32'h8000_0100) begin
            failures++;
            $display("FAIL j_target: iaddr=%h, want 80000100", iaddr);
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        fetch_word(0, $urandom);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc4: pc_plus4=%h, want 00000000", pc_plus4);
        end
        exec_instr(0, 3'd7, 1'b1, $urandom, $urandom, $urandom, 1'b0);
        checks++;
        if (iaddr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_seq: iaddr=%h, want 00000000", iaddr);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            fetch_word(int'($urandom_range(0, 3)), $urandom);
            exec_instr(int'($urandom_range(0, 3)), 3'($urandom), 1'($urandom),
                       $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'b0);
        end
    endtask

    task automatic test_halt();
        fetch_word(1, 32'hFC00_0000);
        exec_instr(1, 3'd3, 1'b0, 32'h0, 32'h0123_4567, 32'h0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ihit = 1'($urandom); iload = $urandom; exec_done = 1'($urandom);
            randomize_controls();
            tick();
            checks++;
            if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0 ||
                pc !== mpc || imemload !== mimem) begin
                failures++;
                $display("FAIL halt_hold: halted=%b iREN=%b valid=%b pc=%h imem=%h, want 1 0 0 %h %h",
                         halted, iREN, instr_valid, pc, imemload, mpc, mimem);
            end
        end
        ihit = 1'b0; exec_done = 1'b0; halt = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        mpc = PC_INIT;
        fetch_word(0, 32'hDEAD_BEEC);
        exec_instr(0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        RST = 1'b1; ihit = 1'b1; iload = 32'h1234_5678;
        #1;
        checks++;
        if (iREN !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_cycle: iREN=%b valid=%b, want 0 0", iREN, instr_valid);
        end
        tick();
        RST = 1'b0; ihit = 1'b0;
        mpc = PC_INIT; mimem = 32'h0;
        #1;
        checks++;
        if (pc !== PC_INIT || instr_valid !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b1) begin
            failures++;
            $display("FAIL reset_midfetch: pc=%h valid=%b imem=%h iREN=%b, want %h 0 0 1",
                     pc, instr_valid, imemload, iREN, PC_INIT);
        end
        fetch_word(1, 32'h8C22_0004);
        exec_instr(1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = '0; exec_done = 1'b0;
        PCsrc = '0; flagZero = 1'b0; BranchAddr = '0; addr = '0; rdat1 = '0; halt = 1'b0;
        mpc = PC_INIT; mimem = '0;
        test_reset();
        test_basic_fetch();
        test_branches();
        test_jumps();
        test_wrap();
        test_random();
        test_halt();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
